// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered immediate decode stage for the RV32/RV64 front end. Each
//   accepted beat is decoded into its instruction format, its sign-extended
//   immediate and its PC-relative target. The decoded result is then stored
//   in a 2-entry FIFO, so fetch and execute stay decoupled under back-pressure.
//
// Parameters
//   XLEN         datapath width, 32 or 64 only
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; clears all state and outputs
//   in_valid     input beat present
//   in_ready     stage can accept a beat (from registered occupancy only)
//   in_instr     raw 32-bit instruction
//   in_pc        instruction address
//   out_valid    head entry present
//   out_ready    consumer accepts the head entry
//   out_imm      sign-extended immediate (Z: zero-extended zimm)
//   out_type     format: I=0 S=1 B=2 U=3 J=4 Z=5 N=6
//   out_target   out_pc + out_imm modulo 2^XLEN
//   out_pc       passthrough of in_pc
//   out_illegal  opcode not supported at this XLEN
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  localparam logic [2:0] T_I = 3'd0;
  localparam logic [2:0] T_S = 3'd1;
  localparam logic [2:0] T_B = 3'd2;
  localparam logic [2:0] T_U = 3'd3;
  localparam logic [2:0] T_J = 3'd4;
  localparam logic [2:0] T_Z = 3'd5;
  localparam logic [2:0] T_N = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } ent_t;

  // Every immediate is first formed as a signed 32-bit value; widening to
  // XLEN is then a plain sign extension (U on RV64 copies instr[31] upward).
  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    logic signed [XLEN-1:0] r;
    r = v;
    return r;
  endfunction

  logic signed [31:0]     imm32_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [2:0]             typ_p0;
  logic                   ill_p0;
  logic [XLEN-1:0]        tgt_p0;
  ent_t                   dec_p0;

  // ---- stage p0: combinational decode and target adder ----
  always_comb begin
    imm32_p0 = '0;
    typ_p0   = T_N;
    ill_p0   = 1'b0;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: begin
        typ_p0   = T_U;
        imm32_p0 = $signed({in_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        typ_p0   = T_J;
        imm32_p0 = $signed({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0});
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
        typ_p0   = T_I;
        imm32_p0 = $signed({{20{in_instr[31]}}, in_instr[31:20]});
      end
      7'b1100011: begin
        typ_p0   = T_B;
        imm32_p0 = $signed({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0});
      end
      7'b0100011: begin
        typ_p0   = T_S;
        imm32_p0 = $signed({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      7'b0110011: begin
        typ_p0 = T_N;
      end
      7'b1110011: begin
        // SYSTEM: funct3[2] selects the CSR-immediate forms carrying zimm.
        if (in_instr[14]) begin
          typ_p0   = T_Z;
          imm32_p0 = $signed({27'b0, in_instr[19:15]});
        end else begin
          typ_p0   = T_I;
          imm32_p0 = $signed({{20{in_instr[31]}}, in_instr[31:20]});
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          typ_p0   = T_I;
          imm32_p0 = $signed({{20{in_instr[31]}}, in_instr[31:20]});
        end else begin
          ill_p0 = 1'b1;
        end
      end
      7'b0111011: begin
        if (XLEN != 64) begin
          ill_p0 = 1'b1;
        end
      end
      // Includes every compressed encoding (instr[1:0] != 2'b11).
      default: begin
        ill_p0 = 1'b1;
      end
    endcase
    imm_p0 = sext_xlen(imm32_p0);
    tgt_p0 = in_pc + $unsigned(imm_p0);
    dec_p0 = '{imm: $unsigned(imm_p0), typ: typ_p0, target: tgt_p0,
               pc: in_pc, illegal: ill_p0};
  end

  ent_t       e0_p1;
  ent_t       e1_p1;
  logic [1:0] count_p1;
  logic       vld_p1;
  logic       push;
  logic       pop;

  assign vld_p1 = (count_p1 != 2'd0);
  assign push   = in_valid & in_ready;
  assign pop    = vld_p1 & out_ready;

  // ---- stage p1: 2-entry result FIFO, e0 is always the head ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p1 <= 2'd0;
      e0_p1    <= '0;
      e1_p1    <= '0;
    end else begin
      case (count_p1)
        2'd0: begin
          if (push) begin
            e0_p1    <= dec_p0;
            count_p1 <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            e0_p1 <= dec_p0;
          end else if (push) begin
            e1_p1    <= dec_p0;
            count_p1 <= 2'd2;
          end else if (pop) begin
            count_p1 <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            e0_p1    <= e1_p1;
            count_p1 <= 2'd1;
          end
        end
      endcase
    end
  end

  assign in_ready    = (count_p1 < 2'd2);
  assign out_valid   = vld_p1;
  assign out_imm     = e0_p1.imm;
  assign out_type    = e0_p1.typ;
  assign out_target  = e0_p1.target;
  assign out_pc      = e0_p1.pc;
  assign out_illegal = e0_p1.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] pc32;
  logic [63:0] pc64;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_target32, out_pc32;
  logic [2:0]  out_type32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_target64, out_pc64;
  logic [2:0]  out_type64;

  int checks   = 0;
  int failures = 0;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(pc32), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_type(out_type32),
    .out_target(out_target32), .out_pc(out_pc32), .out_illegal(out_illegal32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(pc64), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_type(out_type64),
    .out_target(out_target64), .out_pc(out_pc64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm32, tgt32, pc32, imm64, tgt64, pc64;
    logic [2:0]  typ32, typ64;
    logic        ill32, ill64;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the format tables, using integer arithmetic:
  // field values are weighted by their bit position and the sign bit
  // subtracts 2^(width) of the assembled immediate.
  function automatic void ref_decode(input logic [31:0] ins, input bit is64,
                                     input logic [63:0] pc,
                                     output logic [63:0] imm, output logic [2:0] typ,
                                     output logic ill, output logic [63:0] tgt);
    longint v;
    logic [63:0] mask;
    logic [6:0] op;
    v   = 0;
    typ = 3'd6;
    ill = 1'b0;
    op  = ins[6:0];
    case (op)
      7'h37, 7'h17: begin
        typ = 3'd3;
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v = v - 64'sh1_0000_0000;
      end
      7'h6F: begin
        typ = 3'd4;
        v = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * (1 << 12)
          + longint'(ins[20]) * (1 << 11) + longint'(ins[30:21]) * 2;
        if (ins[31]) v = v - (1 << 21);
      end
      7'h67, 7'h03, 7'h13, 7'h0F: begin
        typ = 3'd0;
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        typ = 3'd2;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (ins[31]) v = v - 8192;
      end
      7'h23: begin
        typ = 3'd1;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) v = v - 4096;
      end
      7'h33: typ = 3'd6;
      7'h73: begin
        if (ins[14]) begin
          typ = 3'd5;
          v = longint'(ins[19:15]);
        end else begin
          typ = 3'd0;
          v = longint'(ins[31:20]);
          if (v >= 2048) v = v - 4096;
        end
      end
      7'h1B: begin
        if (is64) begin
          typ = 3'd0;
          v = longint'(ins[31:20]);
          if (v >= 2048) v = v - 4096;
        end else ill = 1'b1;
      end
      7'h3B: if (!is64) ill = 1'b1;
      default: ill = 1'b1;
    endcase
    mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    imm  = 64'(v) & mask;
    tgt  = (pc + 64'(v)) & mask;
  endfunction

  function automatic exp_t make_entry();
    exp_t e;
    e.pc32 = {32'b0, pc32};
    e.pc64 = pc64;
    ref_decode(in_instr, 1'b0, e.pc32, e.imm32, e.typ32, e.ill32, e.tgt32);
    ref_decode(in_instr, 1'b1, e.pc64, e.imm64, e.typ64, e.ill64, e.tgt64);
    return e;
  endfunction

  task automatic check_model();
    chk("in_ready32", 64'(in_ready32), 64'(exp_q.size() < 2));
    chk("in_ready64", 64'(in_ready64), 64'(exp_q.size() < 2));
    chk("out_valid32", 64'(out_valid32), 64'(exp_q.size() > 0));
    chk("out_valid64", 64'(out_valid64), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("imm32", 64'(out_imm32), exp_q[0].imm32);
      chk("type32", 64'(out_type32), 64'(exp_q[0].typ32));
      chk("target32", 64'(out_target32), exp_q[0].tgt32);
      chk("pc32", 64'(out_pc32), exp_q[0].pc32);
      chk("illegal32", 64'(out_illegal32), 64'(exp_q[0].ill32));
      chk("imm64", out_imm64, exp_q[0].imm64);
      chk("type64", 64'(out_type64), 64'(exp_q[0].typ64));
      chk("target64", out_target64, exp_q[0].tgt64);
      chk("pc64", out_pc64, exp_q[0].pc64);
      chk("illegal64", 64'(out_illegal64), 64'(exp_q[0].ill64));
    end
  endtask

  task automatic update_model();
    bit do_push, do_pop;
    if (rst) begin
      exp_q.delete();
    end else begin
      do_push = in_valid && (exp_q.size() < 2);
      do_pop  = (exp_q.size() > 0) && out_ready;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(make_entry());
    end
  endtask

  task automatic tick();
    check_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] p32, input logic [63:0] p64);
    in_valid = 1'b1;
    in_instr = ins;
    pc32     = p32;
    pc64     = p64;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_valid64"}, 64'(out_valid64), 64'd0);
    chk({tag, "_ready32"}, 64'(in_ready32), 64'd1);
    chk({tag, "_ready64"}, 64'(in_ready64), 64'd1);
    chk({tag, "_data32"}, {out_imm32, out_target32}, 64'd0);
    chk({tag, "_misc32"}, {out_pc32, 27'b0, out_type32, 1'b0, out_illegal32}, 64'd0);
    chk({tag, "_imm64"}, out_imm64, 64'd0);
    chk({tag, "_tgt64"}, out_target64, 64'd0);
    chk({tag, "_pc64"}, out_pc64, 64'd0);
    chk({tag, "_misc64"}, {59'b0, out_type64, 1'b0, out_illegal64}, 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF0_0093;
    pc32      = 32'h100;
    pc64      = 64'h100;
    out_ready = 1'b1;
    #1 rst = 1'b1;

    // Reset held with in_valid=1
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs("rst_hold");
    rst      = 1'b0;
    in_valid = 1'b0;

    // I-type addi x1,x0,-1
    push1(32'hFFF0_0093, 32'h100, 64'h100);
    chk("addi_imm", 64'(out_imm32), 64'hFFFF_FFFF);
    chk("addi_type", 64'(out_type32), 64'd0);
    chk("addi_tgt", 64'(out_target32), 64'hFF);
    chk("addi_ill", 64'(out_illegal32), 64'd0);
    tick();

    // jal +8
    push1(32'h0080_006F, 32'h1000, 64'h1000);
    chk("jal_imm", 64'(out_imm32), 64'h8);
    chk("jal_type", 64'(out_type32), 64'd4);
    chk("jal_tgt", 64'(out_target32), 64'h1008);
    tick();
    push1(32'h0080_006F, 32'hFFFF_FFFC, 64'hFFFF_FFFC);
    chk("jal_wrap_tgt", 64'(out_target32), 64'h4);
    tick();

    // Illegal and N
    push1(32'h0000_0000, 32'h40, 64'h40);
    chk("zero_type", 64'(out_type32), 64'd6);
    chk("zero_imm", 64'(out_imm32), 64'd0);
    chk("zero_ill", 64'(out_illegal32), 64'd1);
    tick();
    push1(32'h0020_81B3, 32'h44, 64'h44);
    chk("add_type", 64'(out_type32), 64'd6);
    chk("add_ill", 64'(out_illegal32), 64'd0);
    tick();
    push1(32'h0000_201B, 32'h48, 64'h48);
    chk("w_ill32", 64'(out_illegal32), 64'd1);
    chk("w_ill64", 64'(out_illegal64), 64'd0);
    chk("w_type64", 64'(out_type64), 64'd0);
    tick();

    // RV64 lui and CSR immediate
    push1(32'h8000_00B7, 32'h50, 64'h50);
    chk("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_type64", 64'(out_type64), 64'd3);
    tick();
    push1(32'h340F_D073, 32'h54, 64'h54);
    chk("csr_type32", 64'(out_type32), 64'd5);
    chk("csr_imm32", 64'(out_imm32), 64'h1F);
    chk("csr_type64", 64'(out_type64), 64'd5);
    chk("csr_imm64", out_imm64, 64'h1F);
    tick();

    // Back-pressure: A, B accepted, C held until space frees
    out_ready = 1'b0;
    push1(32'hFFF0_0093, 32'h200, 64'h200);
    push1(32'h0080_006F, 32'h204, 64'h204);
    in_valid = 1'b1;
    in_instr = 32'h0000_0013;
    pc32     = 32'h208;
    pc64     = 64'h208;
    chk("bp_full_ready", 64'(in_ready32), 64'd0);
    tick();
    chk("bp_hold_ready", 64'(in_ready32), 64'd0);
    chk("bp_hold_headA", 64'(out_imm32), 64'hFFFF_FFFF);
    out_ready = 1'b1;
    tick();
    chk("bp_headB", 64'(out_type32), 64'd4);
    tick();
    in_valid = 1'b0;
    chk("bp_headC_type", 64'(out_type32), 64'd0);
    chk("bp_headC_pc", 64'(out_pc32), 64'h208);
    tick();
    tick();

    // Asynchronous reset while full
    out_ready = 1'b0;
    push1(32'h0080_006F, 32'h300, 64'h300);
    push1(32'hFFF0_0093, 32'h304, 64'h304);
    chk("pre_rst_valid", 64'(out_valid32), 64'd1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("rst_async");
    exp_q.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [6:0] ops [13];
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F,
              7'h63, 7'h23, 7'h33, 7'h73, 7'h1B, 7'h3B};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_instr  = $urandom;
      if ($urandom_range(0, 3) != 0) in_instr[6:0] = ops[$urandom_range(0, 12)];
      pc32 = $urandom;
      pc64 = {$urandom, $urandom};
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
